fu_div: RTL and testbench



---
 rtl/fu_div_if.sv | 23 ++
 rtl/fu_div.sv | 204 ++++++++++++++++++++
 tb/tb_fu_div.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fu_div_if.sv
// Issue-side and writeback-side valid/ready channels of the divide unit.
// Payload widths are parameters so the interface carries no package dependency.
interface fu_div_if #(
    parameter int IN_W  = 206,
    parameter int OUT_W = 139
);
    logic             valid_i;
    logic             ready_o;
    logic [IN_W-1:0]  data_i;
    logic             valid_o;
    logic             ready_i;
    logic [OUT_W-1:0] data_o;

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o
    );

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o
    );
endinterface

// File: rtl/fu_div.sv
// Shared FU types and the iterative radix-2 restoring divider (RV64M DIV/REM
// and W forms), one op in flight, result held until writeback takes it.
package C;
    localparam int XLEN  = 64;
    localparam int ID_W  = 5;
    localparam int PRD_W = 6;

    typedef enum logic { SIZE_W = 1'b0, SIZE_D = 1'b1 } size_e;
    typedef enum logic [1:0] { DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU } div_op_e;

    typedef struct packed {
        div_op_e div;
    } fu_op_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [ID_W-1:0]  id;
        logic [PRD_W-1:0] prd;
        fu_op_t           op;
        size_e            size;
        logic [XLEN-1:0]  rs1val;
        logic [XLEN-1:0]  rs2val;
    } fu_input_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [ID_W-1:0]  id;
        logic [PRD_W-1:0] prd;
        logic [XLEN-1:0]  rdval;
    } fu_output_t;
endpackage

// state | meaning
// IDLE  | ready_o=1, accept op; special cases go straight to DONE
// BUSY  | one quotient bit per cycle, cnt_q counts down to 0
// DONE  | valid_o=1, result held until ready_i
module fu_div (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush_i,
    fu_div_if.slave  bus
);
    import C::*;

    typedef enum logic [1:0] { S_IDLE, S_BUSY, S_DONE } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [PRD_W-1:0] prd_q, prd_d;
    logic             quo_sel_q, quo_sel_d;
    logic             word_q, word_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  result_q, result_d;

    fu_input_t        in_w;
    fu_output_t       out_w;
    logic             is_word, is_signed, a_neg, b_neg, div_zero, ovf, quo_sel_in;
    logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, min_neg;
    logic [XLEN:0]    rem_shift, rem_sub;
    logic             fits;
    logic [XLEN-1:0]  rem_step, quo_step, q_fin, r_fin;

    function automatic logic [XLEN-1:0] fit(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    assign in_w = bus.data_i;

    always_comb begin
        is_word    = (in_w.size == SIZE_W);
        is_signed  = (in_w.op.div == DIV_DIV) || (in_w.op.div == DIV_REM);
        quo_sel_in = (in_w.op.div == DIV_DIV) || (in_w.op.div == DIV_DIVU);
        a_ext = is_word ? {{(XLEN-32){is_signed & in_w.rs1val[31]}}, in_w.rs1val[31:0]}
                        : in_w.rs1val;
        b_ext = is_word ? {{(XLEN-32){is_signed & in_w.rs2val[31]}}, in_w.rs2val[31:0]}
                        : in_w.rs2val;
        a_neg    = is_signed & a_ext[XLEN-1];
        b_neg    = is_signed & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        min_neg  = is_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        ovf      = is_signed && (a_ext == min_neg) && (b_ext == '1);
    end

    // Borrow out of the N+1-bit trial subtract says the divisor did not fit.
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        rem_sub   = rem_shift - {1'b0, divisor_q};
        fits      = ~rem_sub[XLEN];
        rem_step  = fits ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_step  = {quo_q[XLEN-2:0], fits};
        q_fin     = negq_q ? -quo_step : quo_step;
        r_fin     = negr_q ? -rem_step : rem_step;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        id_d      = id_q;
        prd_d     = prd_q;
        quo_sel_d = quo_sel_q;
        word_d    = word_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        result_d  = result_q;

        bus.ready_o = (state_q == S_IDLE);
        bus.valid_o = (state_q == S_DONE);
        out_w.pc    = pc_q;
        out_w.id    = id_q;
        out_w.prd   = prd_q;
        out_w.rdval = result_q;
        bus.data_o  = out_w;

        case (state_q)
            S_IDLE: begin
                if (bus.valid_i && !flush_i) begin
                    pc_d      = in_w.pc;
                    id_d      = in_w.id;
                    prd_d     = in_w.prd;
                    quo_sel_d = quo_sel_in;
                    word_d    = is_word;
                    negq_d    = a_neg ^ b_neg;
                    negr_d    = a_neg;
                    if (div_zero || ovf) begin
                        if (quo_sel_in)
                            result_d = fit(is_word, div_zero ? '1 : a_ext);
                        else
                            result_d = fit(is_word, div_zero ? a_ext : '0);
                        state_d = S_DONE;
                    end else begin
                        divisor_d = b_mag;
                        // W dividends are pre-aligned to the top so 32 shifts suffice.
                        quo_d     = is_word ? {a_mag[31:0], 32'b0} : a_mag;
                        rem_d     = '0;
                        cnt_d     = is_word ? 7'd31 : 7'd63;
                        state_d   = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd0) begin
                        result_d = fit(word_q, quo_sel_q ? q_fin : r_fin);
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.ready_i || flush_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            id_q      <= '0;
            prd_q     <= '0;
            quo_sel_q <= 1'b0;
            word_q    <= 1'b0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            cnt_q     <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            id_q      <= id_d;
            prd_q     <= prd_d;
            quo_sel_q <= quo_sel_d;
            word_q    <= word_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
        end
    end
endmodule

// File: tb/tb_fu_div.sv
// Directed bench for fu_div: latency, results, special cases, backpressure,
// flush and reset abort, all against hand-computed values.
module tb_fu_div;
    import C::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_i = 1'b0;
    int   checks = 0;
    int   failures = 0;

    fu_div_if #(.IN_W($bits(fu_input_t)), .OUT_W($bits(fu_output_t))) bus ();

    fu_div dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    fu_input_t  din;
    fu_output_t dout;
    int         lat;
    logic [63:0] rd;
    logic [63:0] held;
    int          seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.ready_o !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
    endtask

    // Issue one op; returns cycles from accept to first valid_o and the rdval seen then.
    task automatic run_op(input div_op_e op, input size_e sz, input logic [63:0] a,
                          input logic [63:0] b, output int l, output logic [63:0] r);
        wait_idle();
        din.op.div  = op;
        din.size    = sz;
        din.rs1val  = a;
        din.rs2val  = b;
        bus.data_i  = din;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        l = 1;
        while (bus.valid_o !== 1'b1 && l < 200) begin
            @(posedge clk); #1; l++;
        end
        dout = bus.data_o;
        r = dout.rdval;
    endtask

    task automatic start_op(input div_op_e op, input size_e sz, input logic [63:0] a,
                            input logic [63:0] b);
        wait_idle();
        din.op.div  = op;
        din.size    = sz;
        din.rs1val  = a;
        din.rs2val  = b;
        bus.data_i  = din;
        bus.valid_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        din = '0;
        din.pc  = 64'h0000_0000_0000_1000;
        din.id  = 5'd3;
        din.prd = 6'd7;
        bus.data_i = din;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        dout = bus.data_o;
        check("reset_ready", {63'b0, bus.ready_o}, 64'd1);
        check("reset_valid", {63'b0, bus.valid_o}, 64'd0);
        check("reset_rdval", dout.rdval, 64'd0);
        check("reset_pc", dout.pc, 64'd0);

        run_op(DIV_DIVU, SIZE_D, 64'd100, 64'd7, lat, rd);
        check("divu_lat", 64'(lat), 64'd65);
        check("divu_val", rd, 64'd14);
        run_op(DIV_REMU, SIZE_D, 64'd100, 64'd7, lat, rd);
        check("remu_val", rd, 64'd2);

        run_op(DIV_DIV, SIZE_D, -64'sd100, 64'd7, lat, rd);
        check("div_lat", 64'(lat), 64'd65);
        check("div_neg", rd, 64'hFFFF_FFFF_FFFF_FFF2);
        run_op(DIV_REM, SIZE_D, -64'sd100, 64'd7, lat, rd);
        check("rem_neg", rd, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(DIV_REM, SIZE_D, 64'd100, -64'sd7, lat, rd);
        check("rem_negdivisor", rd, 64'd2);

        run_op(DIV_DIV, SIZE_W, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, rd);
        check("divw_ovf_lat", 64'(lat), 64'd1);
        check("divw_ovf_val", rd, 64'hFFFF_FFFF_8000_0000);
        run_op(DIV_REM, SIZE_W, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, rd);
        check("remw_ovf_val", rd, 64'd0);

        run_op(DIV_DIVU, SIZE_D, 64'd5, 64'd0, lat, rd);
        check("divu_zero_lat", 64'(lat), 64'd1);
        check("divu_zero_val", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(DIV_REMU, SIZE_W, 64'hFFFF_FFFF_8000_0001, 64'd0, lat, rd);
        check("remuw_zero_val", rd, 64'hFFFF_FFFF_8000_0001);

        run_op(DIV_DIVU, SIZE_W, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat, rd);
        check("divuw_lat", 64'(lat), 64'd33);
        check("divuw_sext", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(DIV_REMU, SIZE_W, 64'hABCD_0000_FFFF_FFFF, 64'd16, lat, rd);
        check("remuw_val", rd, 64'd15);

        // Backpressure with distinctive tags.
        wait_idle();
        bus.ready_i = 1'b0;
        din.pc  = 64'h0000_0000_8000_1234;
        din.id  = 5'h15;
        din.prd = 6'h2A;
        run_op(DIV_DIV, SIZE_W, 64'h0000_0000_FFFF_FFEC, 64'd3, lat, rd);
        check("bp_lat", 64'(lat), 64'd33);
        check("bp_val", rd, 64'hFFFF_FFFF_FFFF_FFFA);
        check("bp_pc", dout.pc, 64'h0000_0000_8000_1234);
        check("bp_id", 64'(dout.id), 64'h15);
        check("bp_prd", 64'(dout.prd), 64'h2A);
        held = rd;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            dout = bus.data_o;
            check("bp_hold_valid", {63'b0, bus.valid_o}, 64'd1);
            check("bp_hold_ready", {63'b0, bus.ready_o}, 64'd0);
            check("bp_hold_data", dout.rdval, held);
        end
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", {63'b0, bus.ready_o}, 64'd1);
        check("bp_release_valid", {63'b0, bus.valid_o}, 64'd0);

        // Flush in BUSY cycle 20.
        start_op(DIV_DIVU, SIZE_D, 64'd1000, 64'd3);
        repeat (19) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush_ready", {63'b0, bus.ready_o}, 64'd1);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (bus.valid_o === 1'b1) seen++;
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        run_op(DIV_DIVU, SIZE_W, 64'd9, 64'd2, lat, rd);
        check("after_flush_lat", 64'(lat), 64'd33);
        check("after_flush_val", rd, 64'd4);

        // Same again with reset as the abort.
        start_op(DIV_DIVU, SIZE_D, 64'd1000, 64'd3);
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dout = bus.data_o;
        check("rst_ready", {63'b0, bus.ready_o}, 64'd1);
        check("rst_data_clear", dout.rdval, 64'd0);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (bus.valid_o === 1'b1) seen++;
        end
        check("rst_no_valid", 64'(seen), 64'd0);
        run_op(DIV_DIVU, SIZE_W, 64'd9, 64'd2, lat, rd);
        check("after_rst_lat", 64'(lat), 64'd33);
        check("after_rst_val", rd, 64'd4);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
